// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - shared constants and types for the seven-segment scanner
// Holds the digit count, the segment bit positions, the hex glyph table and the
// display-configuration record that is double-buffered by the scanner.
package seven_seg_scanner_pkg;

   localparam int NUM_DIGITS = 4;

   // Segment bit positions within io_seg (active-low on the pins).
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-high a..g glyphs; element n is the glyph for hex digit n.
   localparam logic [15:0][6:0] HEX_GLYPHS = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef struct packed {
      logic [15:0]           value;
      logic [NUM_DIGITS-1:0] dp;
      logic                  lz;
   } disp_cfg_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - load handshake bundle for the seven-segment scanner
// load_valid : value_in/dp_in/lz_en presented this cycle
// load_ready : scanner accepts loads (1 after reset)
// value_in   : four hex nibbles, [3:0] is the rightmost digit
// dp_in      : decimal point per digit, 1 = lit
// lz_en      : leading-zero suppression enable, captured with the value
interface seven_seg_scanner_if;
   import seven_seg_scanner_pkg::*;

   logic                  load_valid;
   logic                  load_ready;
   logic [15:0]           value_in;
   logic [NUM_DIGITS-1:0] dp_in;
   logic                  lz_en;

   modport master (output load_valid, value_in, dp_in, lz_en, input load_ready);
   modport slave  (input load_valid, value_in, dp_in, lz_en, output load_ready);

endinterface

// File: rtl/seven_seg_scanner_decoder.sv
// rtl/seven_seg_scanner_decoder.sv - hex nibble to active-high seven-segment glyph
// nibble : 4-bit hex digit in
// seg    : active-high segments, bit0 = a .. bit6 = g
module seven_seg_decoder
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = HEX_GLYPHS[nibble];
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed four-digit seven-segment driver
// clk, rst_n  : system clock, asynchronous active-low reset
// load_if     : load handshake (slave side); loads go to a pending buffer
// io_seg      : segments, active-low, bit0 = a .. bit6 = g, bit7 = dp
// io_sel      : digit enables, active-low, bit k = digit k
// frame_done  : one-cycle pulse coinciding with the first blank of the digit-0 slot
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 500
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   seven_seg_scanner_if.slave     load_if,
   output logic [7:0]             io_seg,
   output logic [NUM_DIGITS-1:0]  io_sel,
   output logic                   frame_done
);

   localparam int             CW      = $clog2(DIGIT_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_BLK = CW'(BLANK_CYCLES);

   logic [1:0]            digit_q, digit_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   disp_cfg_t             pend_q, pend_d;
   logic                  pend_full_q, pend_full_d;
   disp_cfg_t             act_q, act_d;
   logic                  load_ready_q, load_ready_d;
   logic                  wrap_q, wrap_d;
   logic [7:0]            io_seg_q, io_seg_d;
   logic [NUM_DIGITS-1:0] io_sel_q, io_sel_d;
   logic                  frame_done_q, frame_done_d;

   logic                  frame_end;
   disp_cfg_t             load_cfg;
   logic [15:0]           upper;
   logic [3:0]            nibble;
   logic [6:0]            glyph;
   logic                  lz_blank;

   // Only the currently scanned nibble is decoded.
   seven_seg_decoder u_decoder (
      .nibble (nibble),
      .seg    (glyph)
   );

   always_comb begin
      load_cfg = '{value: load_if.value_in, dp: load_if.dp_in, lz: load_if.lz_en};
      frame_end = (digit_q == 2'd3) && (cnt_q == CNT_MAX);

      // Scan counters.
      cnt_d   = cnt_q + 1'b1;
      digit_d = digit_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         digit_d = digit_q + 2'd1;
      end

      // Double buffer: loads land in pending; active only changes at frame end.
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      act_d       = act_q;
      if (load_if.load_valid) begin
         pend_d      = load_cfg;
         pend_full_d = 1'b1;
      end
      if (frame_end) begin
         if (load_if.load_valid) begin
            act_d       = load_cfg;
            pend_full_d = 1'b0;
         end else if (pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
         end
      end

      // Everything at and above the scanned digit, for leading-zero detection.
      upper    = act_q.value >> {digit_q, 2'b00};
      nibble   = upper[3:0];
      lz_blank = act_q.lz && (digit_q != 2'd0) && (upper == 16'h0000);

      io_sel_d = '1;
      io_seg_d = '1;
      if (cnt_q >= CNT_BLK) begin
         io_sel_d                 = ~(4'b0001 << digit_q);
         io_seg_d[SEG_DP]         = ~act_q.dp[digit_q];
         io_seg_d[SEG_G:SEG_A]    = lz_blank ? 7'h7F : ~glyph;
      end

      // Delayed one extra cycle so the pulse lines up with the digit-0 blank on io_sel.
      wrap_d       = frame_end;
      frame_done_d = wrap_q;
      load_ready_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q      <= '0;
         cnt_q        <= '0;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         act_q        <= '0;
         load_ready_q <= 1'b0;
         wrap_q       <= 1'b0;
         io_seg_q     <= 8'hFF;
         io_sel_q     <= '1;
         frame_done_q <= 1'b0;
      end else begin
         digit_q      <= digit_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         act_q        <= act_d;
         load_ready_q <= load_ready_d;
         wrap_q       <= wrap_d;
         io_seg_q     <= io_seg_d;
         io_sel_q     <= io_sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign load_if.load_ready = load_ready_q;
   assign io_seg             = io_seg_q;
   assign io_sel             = io_sel_q;
   assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

   logic       clk;
   logic       rst_n;
   logic [7:0] io_seg;
   logic [3:0] io_sel;
   logic       frame_done;

   int n_checks;
   int n_fail;
   int k;          // posedges since reset release
   logic ld_en;

   seven_seg_scanner_if bus ();

   seven_seg_scanner #(
      .DIGIT_CYCLES (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_if    (bus.slave),
      .io_seg     (io_seg),
      .io_sel     (io_sel),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load table: load_valid is driven in the cycle after posedge number ld_k.
   localparam int NLD = 5;
   int          ld_k   [NLD] = '{10, 40, 50, 70, 127};
   logic [15:0] ld_val [NLD] = '{16'h1A8F, 16'h1111, 16'h2222, 16'h0005, 16'hC3E7};
   logic [3:0]  ld_dp  [NLD] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};
   logic        ld_lz  [NLD] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      bus.load_valid = 1'b0;
      bus.value_in   = 16'h0000;
      bus.dp_in      = 4'h0;
      bus.lz_en      = 1'b0;
      if (ld_en) begin
         for (int i = 0; i < NLD; i++) begin
            if (ld_k[i] == k) begin
               bus.load_valid = 1'b1;
               bus.value_in   = ld_val[i];
               bus.dp_in      = ld_dp[i];
               bus.lz_en      = ld_lz[i];
            end
         end
      end
   endtask

   // Checks n cycles of output; s0..s3 are the expected lit io_seg per digit.
   task automatic run_frame(input int n, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
      logic [7:0] segs [4];
      int p, d, c;
      logic [3:0] exp_sel;
      logic [7:0] exp_seg;
      segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
      for (int i = 0; i < n; i++) begin
         tick();
         p = (k - 1) % 32;
         d = p / 8;
         c = p % 8;
         if (c < 2) begin
            exp_sel = 4'hF;
            exp_seg = 8'hFF;
         end else begin
            exp_sel = ~(4'b0001 << d);
            exp_seg = segs[d];
         end
         check("io_sel", 32'(io_sel), 32'(exp_sel));
         check("io_seg", 32'(io_seg), 32'(exp_seg));
         check("frame_done", 32'(frame_done), 32'((p == 0) && (k != 1)));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      k        = 0;
      ld_en    = 1'b1;
      rst_n    = 1'b0;
      bus.load_valid = 1'b0;
      bus.value_in   = 16'h0000;
      bus.dp_in      = 4'h0;
      bus.lz_en      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", 32'(io_seg), 32'hFF);
      check("rst_sel", 32'(io_sel), 32'hF);
      check("rst_fd", 32'(frame_done), 32'h0);
      check("rst_ready", 32'(bus.load_ready), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      k = 0;

      // Frame 0: zeros; 1A8F loaded mid-frame must not show yet.
      run_frame(32, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      check("ready", 32'(bus.load_ready), 32'h1);
      // Frame 1: 1A8F; loads 1111 then 2222.
      run_frame(32, 8'h8E, 8'h80, 8'h88, 8'hF9);
      // Frame 2: only 2222; load 0005 with lz and dp on digit 2.
      run_frame(32, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
      // Frame 3: suppressed zeros; C3E7 loaded on the frame-end cycle.
      run_frame(32, 8'h92, 8'hFF, 8'h7F, 8'hFF);
      // Frames 4 and 5: C3E7 immediately, and unchanged afterwards.
      run_frame(32, 8'h78, 8'h86, 8'hB0, 8'hC6);
      run_frame(16, 8'h78, 8'h86, 8'hB0, 8'hC6);

      // Pending load, then asynchronous reset mid-slot.
      bus.load_valid = 1'b1;
      bus.value_in   = 16'h4BD6;
      bus.dp_in      = 4'hF;
      bus.lz_en      = 1'b0;
      ld_en = 1'b0;
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_seg", 32'(io_seg), 32'hFF);
      check("arst_sel", 32'(io_sel), 32'hF);
      check("arst_fd", 32'(frame_done), 32'h0);
      check("arst_ready", 32'(bus.load_ready), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;

      // Pending value discarded: two frames of zeros.
      run_frame(32, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      run_frame(32, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
